// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port matrix arbiter.
package noc_arb_pkg;

    localparam int N_MAX = 16;
    localparam int IDX_W_MAX = $clog2(N_MAX);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int onehot_to_idx(input logic [N_MAX-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < N_MAX; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    // Packed position of p[i][j] (i > j) in the lower-triangle flop vector.
    function automatic int tri_idx(input int i, input int j);
        return (i * (i - 1)) / 2 + j;
    endfunction

endpackage

// File: rtl/arb_matrix_core.sv
// Triangular priority matrix with combinational grant; winner drops to lowest priority on upd.
module arb_matrix_core
    import noc_arb_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         upd,
    input  logic [N-1:0] win_oh,
    output logic [N-1:0] gnt
);

    localparam int NP = (N * (N - 1)) / 2;

    logic [NP-1:0] pri_q;
    logic [NP-1:0] pri_d;

    always_comb begin
        gnt = req;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j < i) begin
                    gnt[i] = gnt[i] & (~req[j] | pri_q[tri_idx(i, j)]);
                end else if (j > i) begin
                    gnt[i] = gnt[i] & (~req[j] | ~pri_q[tri_idx(j, i)]);
                end
            end
        end
    end

    always_comb begin
        pri_d = pri_q;
        if (upd) begin
            for (int i = 1; i < N; i++) begin
                for (int j = 0; j < i; j++) begin
                    if (win_oh[i]) begin
                        pri_d[tri_idx(i, j)] = 1'b0;
                    end else if (win_oh[j]) begin
                        pri_d[tri_idx(i, j)] = 1'b1;
                    end
                end
            end
        end
    end

    // All ones: the highest index starts with the highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= '1;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/arbiter_matrix_wh.sv
// NoC output-port arbiter: least-recently-granted matrix plus wormhole packet lock.
//   state      | meaning
//   ARB_IDLE   | arbitrating each cycle; a head transfer updates priority
//   ARB_LOCKED | output owned by `owner` until its tail flit transfers
module arbiter_matrix_wh
    import noc_arb_pkg::*;
#(
    parameter int N       = 5,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic                 out_ready,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic                 xfer,
    output logic                 locked,
    output logic [$clog2(N)-1:0] owner
);

    localparam int IDX_W = $clog2(N);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N-1:0]     core_gnt;
    logic [N-1:0]     lock_gnt;
    logic             tail;
    logic             upd;

    arb_matrix_core #(.N(N)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .upd    (upd),
        .win_oh (core_gnt),
        .gnt    (core_gnt)
    );

    assign locked    = (state_q == ARB_LOCKED);
    assign lock_gnt  = N'(1) << owner_q;
    assign gnt       = locked ? lock_gnt : core_gnt;
    assign gnt_valid = |gnt;
    assign xfer      = gnt_valid & (|(gnt & req)) & out_ready;
    assign tail      = |(gnt & last);
    assign upd       = xfer & ~locked;
    assign owner     = owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer && !tail) begin
                    state_d = ARB_LOCKED;
                    owner_d = IDX_W'(onehot_to_idx(N_MAX'(core_gnt)));
                end
            end
            ARB_LOCKED: begin
                if (xfer && tail) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        // Flit-level mode: never lock, owner keeps its reset value.
        if (!LOCK_EN) begin
            state_d = ARB_IDLE;
            owner_d = owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_arbiter_matrix_wh.sv
// Directed bench for arbiter_matrix_wh: wormhole instance plus a flit-level (LOCK_EN=0) instance.
module tb_arbiter_matrix_wh;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req, last;
    logic       out_ready;
    logic [4:0] gnt;
    logic       gnt_valid, xfer, locked;
    logic [2:0] owner;

    logic [4:0] req_b, last_b;
    logic       rdy_b;
    logic [4:0] gnt_b;
    logic       gnt_valid_b, xfer_b, locked_b;
    logic [2:0] owner_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arbiter_matrix_wh #(.N(5), .LOCK_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .xfer      (xfer),
        .locked    (locked),
        .owner     (owner)
    );

    arbiter_matrix_wh #(.N(5), .LOCK_EN(1'b0)) dut_flit (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_b),
        .last      (last_b),
        .out_ready (rdy_b),
        .gnt       (gnt_b),
        .gnt_valid (gnt_valid_b),
        .xfer      (xfer_b),
        .locked    (locked_b),
        .owner     (owner_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] rot [5];
        rot[0] = 5'b10000; rot[1] = 5'b01000; rot[2] = 5'b00100;
        rot[3] = 5'b00010; rot[4] = 5'b00001;

        rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
        req_b = '0; last_b = '0; rdy_b = 1'b0;
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_valid", gnt_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All request, single-flit packets: rotate from highest index down.
        req = 5'b11111; last = 5'b11111; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rot_gnt", gnt, rot[k]);
            chk("rot_xfer", xfer, 1);
            chk("rot_locked", locked, 0);
            step();
        end
        chk("rot_wrap_gnt", gnt, 5'b10000);

        // Stall without out_ready: grant held, no transfer, no priority change.
        req = 5'b00011; out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_gnt", gnt, 5'b00010);
            chk("stall_xfer", xfer, 0);
            chk("stall_gnt_valid", gnt_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_xfer", xfer, 1);
        step();
        chk("after_stall_gnt", gnt, 5'b00001);

        // Singles from 4 then 0 so input 3 leads, then 4, then 0.
        req = 5'b10000;
        #1;
        chk("pre4_gnt", gnt, 5'b10000);
        step();
        chk("single_no_lock", locked, 0);
        req = 5'b00001;
        #1;
        chk("pre0_gnt", gnt, 5'b00001);
        step();

        // 4-flit worm from input 3; non-owner last bits must not end it.
        req = 5'b11001; last = 5'b10001;
        #1;
        chk("worm_head_gnt", gnt, 5'b01000);
        chk("worm_head_locked", locked, 0);
        step();
        chk("worm_locked", locked, 1);
        chk("worm_owner", owner, 3);
        for (int k = 0; k < 2; k++) begin
            chk("worm_body_gnt", gnt, 5'b01000);
            chk("worm_body_xfer", xfer, 1);
            step();
            chk("worm_body_locked", locked, 1);
        end
        last = 5'b11001;
        #1;
        chk("worm_tail_gnt", gnt, 5'b01000);
        step();
        chk("worm_done_locked", locked, 0);
        chk("worm_next_gnt", gnt, 5'b10000);

        // Lock on input 2, then a 2-cycle bubble.
        req = 5'b00100; last = 5'b00000;
        #1;
        chk("bub_head_gnt", gnt, 5'b00100);
        step();
        chk("bub_locked", locked, 1);
        chk("bub_owner", owner, 2);
        req = 5'b00011;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("bub_gnt", gnt, 5'b00100);
            chk("bub_xfer", xfer, 0);
            chk("bub_hold_locked", locked, 1);
            step();
        end
        req = 5'b00111; last = 5'b00100;
        #1;
        chk("bub_resume_gnt", gnt, 5'b00100);
        chk("bub_resume_xfer", xfer, 1);
        step();
        chk("bub_done_locked", locked, 0);

        // Lock on input 1, then async reset between clock edges.
        req = 5'b00011; last = 5'b00000;
        #1;
        chk("rl_head_gnt", gnt, 5'b00010);
        step();
        chk("rl_locked", locked, 1);
        chk("rl_owner", owner, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_owner", owner, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 5'b00011;
        #1;
        chk("post_rst_gnt", gnt, 5'b00010);
        req = 5'b00000;

        // Flit-level instance: two multi-flit senders alternate every cycle.
        req_b = 5'b00110; last_b = 5'b00000; rdy_b = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("flit_gnt", gnt_b, (k % 2 == 0) ? 5'b00100 : 5'b00010);
            chk("flit_xfer", xfer_b, 1);
            chk("flit_locked", locked_b, 0);
            step();
        end
        chk("flit_owner", owner_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
